// File: rtl/upcounter_ctrl.sv
// -----------------------------------------------------------------------------
// upcounter_ctrl
//   Run/stop/clear controller for the 0..COUNT_MAX up-counter that feeds the
//   4-digit FND display path. Two raw push-buttons are synchronised,
//   debounced and rising-edge detected. A STOP/RUN/CLEAR state machine
//   sequences the counter. A prescaler derives the count-enable tick from
//   the system clock.
//
//   Ports:
//     clk           in   system clock, all logic on the rising edge
//     reset         in   asynchronous active-low reset
//     btn_run_stop  in   raw run/stop button, active-high, asynchronous
//     btn_clear     in   raw clear button, active-high, asynchronous
//     count[13:0]   out  current count 0..COUNT_MAX, registered
//     o_run         out  high while the FSM is in RUN, registered
//     o_tick        out  one-clock pulse on every increment, registered
// -----------------------------------------------------------------------------

// Button conditioner: 2-FF synchroniser, debounce filter, rising-edge pulse.
module upcounter_ctrl_btn #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_edge
);

  localparam int unsigned DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          level_prev_q, level_prev_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;

  // Next-state logic for synchroniser, debounce filter and edge history.
  always_comb begin
    sync1_d      = btn_raw;
    sync2_d      = sync1_q;
    level_prev_d = level_q;
    level_d      = level_q;
    db_cnt_d     = '0;
    // The counter only runs while the synced input disagrees with the
    // accepted level; any agreement restarts the stability window.
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d  = sync2_q;
        db_cnt_d = '0;
      end else begin
        level_d  = level_q;
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end else begin
      level_d  = level_q;
      db_cnt_d = '0;
    end
  end

  // Conditioner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      db_cnt_q     <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      db_cnt_q     <= db_cnt_d;
    end
  end

  // Press pulse: accepted level rose on the previous clock; release is silent.
  assign btn_edge = level_q & ~level_prev_q;

endmodule

module upcounter_ctrl #(
  parameter int unsigned TICK_DIV     = 10_000_000,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned COUNT_MAX    = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_run_stop,
  input  logic        btn_clear,
  output logic [13:0] count,
  output logic        o_run,
  output logic        o_tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [13:0]   CNT_MAX    = 14'(COUNT_MAX);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [13:0]   count_q, count_d;
  logic          run_q, run_d;
  logic          tick_q, tick_d;
  logic          run_edge;
  logic          clear_edge;

  upcounter_ctrl_btn #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_run (
    .clk      (clk),
    .rst_n    (reset),
    .btn_raw  (btn_run_stop),
    .btn_edge (run_edge)
  );

  upcounter_ctrl_btn #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_clear (
    .clk      (clk),
    .rst_n    (reset),
    .btn_raw  (btn_clear),
    .btn_edge (clear_edge)
  );

  // FSM next-state: clear beats run in STOP; edges in CLEAR are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (clear_edge) begin
          state_d = ST_CLEAR;
        end else if (run_edge) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_RUN: begin
        if (run_edge) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_CLEAR: state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_STOP;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath next values; driven by the current state so a stop request on a
  // terminal prescaler clock still lets that increment through.
  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    tick_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          tick_d  = 1'b1;
          if (count_q >= CNT_MAX) begin
            count_d = 14'd0;
          end else begin
            count_d = count_q + 14'd1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
          count_d = count_q;
        end
      end
      ST_CLEAR: begin
        presc_d = '0;
        count_d = 14'd0;
      end
      // STOP holds the partial prescaler period so RUN resumes in phase.
      default: begin
        presc_d = presc_q;
        count_d = count_q;
      end
    endcase
    run_d = (state_d == ST_RUN);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      count_q <= 14'd0;
      run_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      run_q   <= run_d;
      tick_q  <= tick_d;
    end
  end

  assign count  = count_q;
  assign o_run  = run_q;
  assign o_tick = tick_q;

endmodule
